// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential PCs to imem and queues in-order responses for decode.
// Latency: request at cycle t, response at t+1 at the earliest, instruction visible to decode at t+2.
// Backpressure: requests stop once queued entries plus discarded in-flight responses reach QUEUE_DEPTH.
//
// Ports:
//   clk, rst                           clock and synchronous active-high reset
//   redirect, redirect_pc              taken branch/jump: flush the queue and restart fetch at the target
//   imem_req_valid/_ready/_addr        fetch request handshake to instruction memory
//   imem_resp_valid/_data              in-order memory responses (no ready; always accepted)
//   inst_valid/_ready, inst, inst_pc   head instruction handshake to decode
//   fetch_pc                           current fetch PC register
module fetch_unit #(
    parameter int                       WORD_BITWIDTH = 32,
    parameter logic [WORD_BITWIDTH-1:0] RESET_PC      = '0,
    parameter int                       QUEUE_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [WORD_BITWIDTH-1:0] redirect_pc,
    output logic                     imem_req_valid,
    output logic [WORD_BITWIDTH-1:0] imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_resp_valid,
    input  logic [WORD_BITWIDTH-1:0] imem_resp_data,
    output logic                     inst_valid,
    output logic [WORD_BITWIDTH-1:0] inst,
    output logic [WORD_BITWIDTH-1:0] inst_pc,
    input  logic                     inst_ready,
    output logic [WORD_BITWIDTH-1:0] fetch_pc
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    logic [WORD_BITWIDTH-1:0] r_fetch_pc;
    logic [WORD_BITWIDTH-1:0] r_pc_q   [QUEUE_DEPTH];
    logic [WORD_BITWIDTH-1:0] r_inst_q [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]   r_filled;
    logic [PW-1:0]            r_alloc_ptr;
    logic [PW-1:0]            r_fill_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;   // allocated entries
    logic [CW-1:0]            r_pend;    // allocated entries still waiting for their response
    logic [CW-1:0]            r_drop;    // in-flight responses that belong to a flushed stream

    logic [CW:0]              w_occupancy;
    logic                     w_req_vld;
    logic                     w_req_fire;
    logic                     w_head_vld;
    logic                     w_deq;
    logic                     w_resp_fill;
    logic                     w_resp_drop;
    logic [CW-1:0]            w_drop_sum;
    logic [CW-1:0]            w_drop_redir;

    // Discarded responses still occupy memory bandwidth slots, so they count against queue space.
    assign w_occupancy = {1'b0, r_count} + {1'b0, r_drop};
    assign w_req_vld   = !redirect && (w_occupancy < (CW+1)'(QUEUE_DEPTH));
    assign w_req_fire  = w_req_vld && imem_req_ready;

    // r_filled is not cleared on flush; the count guard hides stale flags until the slot is reallocated.
    assign w_head_vld  = (r_count != '0) && r_filled[r_rd_ptr];
    assign w_deq       = w_head_vld && !redirect && inst_ready;

    assign w_resp_fill = imem_resp_valid && (r_drop == '0) && (r_pend != '0);
    assign w_resp_drop = imem_resp_valid && (r_drop != '0);

    // On flush every unfilled entry becomes a response to discard; a response arriving
    // in the flush cycle itself is discarded immediately.
    assign w_drop_sum   = r_drop + r_pend;
    assign w_drop_redir = (imem_resp_valid && (w_drop_sum != '0)) ? w_drop_sum - CW'(1) : w_drop_sum;

    assign imem_req_valid = w_req_vld;
    assign imem_req_addr  = r_fetch_pc;
    assign fetch_pc       = r_fetch_pc;
    assign inst_valid     = w_head_vld && !redirect;
    assign inst           = r_inst_q[r_rd_ptr];
    assign inst_pc        = r_pc_q[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_filled    <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pend      <= '0;
            r_drop      <= '0;
        end else if (redirect) begin
            r_fetch_pc  <= redirect_pc & ~WORD_BITWIDTH'(3);
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pend      <= '0;
            r_drop      <= w_drop_redir;
        end else begin
            if (w_req_fire) begin
                r_pc_q[r_alloc_ptr]   <= r_fetch_pc;
                r_filled[r_alloc_ptr] <= 1'b0;
                r_alloc_ptr           <= r_alloc_ptr + PW'(1);
                r_fetch_pc            <= r_fetch_pc + WORD_BITWIDTH'(4);
            end
            // A fill never targets the slot being allocated: fill needs r_pend > 0,
            // allocation needs a free slot, so the two pointers differ whenever both fire.
            if (w_resp_fill) begin
                r_inst_q[r_fill_ptr] <= imem_resp_data;
                r_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_req_fire) - CW'(w_deq);
            r_pend  <= r_pend + CW'(w_req_fire) - CW'(w_resp_fill);
            r_drop  <= r_drop - CW'(w_resp_drop);
        end
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WORD_BITWIDTH, default 32: width of PCs, addresses and instruction words.
REQ-002 Parameter RESET_PC, default 0: fetch address after reset.
REQ-003 Parameter QUEUE_DEPTH, default 4: fetch queue entries; power of two, at least 2.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port redirect  input  1: taken branch/jump; replaces the sequential PC.
REQ-007 Port redirect_pc  input  WORD_BITWIDTH: redirect target.
REQ-008 Port imem_req_valid  output  1: fetch request valid.
REQ-009 Port imem_req_addr  output  WORD_BITWIDTH: fetch address; equals fetch_pc.
REQ-010 Port imem_req_ready  input  1: memory accepts the request.
REQ-011 Port imem_resp_valid  input  1: in-order response valid; any latency of 1 or more cycles.
REQ-012 Port imem_resp_data  input  WORD_BITWIDTH: fetched instruction word.
REQ-013 Port inst_valid  output  1: head instruction available to decode.
REQ-014 Port inst  output  WORD_BITWIDTH: head instruction word.
REQ-015 Port inst_pc  output  WORD_BITWIDTH: PC of the head instruction.
REQ-016 Port inst_ready  input  1: decode consumes the head instruction (stall when low).
REQ-017 Port fetch_pc  output  WORD_BITWIDTH: current fetch PC register.

Function
REQ-018 Handshakes: request fires on imem_req_valid and imem_req_ready high; dequeue fires on inst_valid and inst_ready high.
REQ-019 Queue entries: allocated at request handshake, holding the PC and an unfilled flag.
REQ-020 Queue pointers: alloc, fill and read pointers wrap modulo QUEUE_DEPTH; count and drop counters are clog2(QUEUE_DEPTH)+1 bits wide.
REQ-021 Request gating: imem_req_valid = !redirect && (count + drop < QUEUE_DEPTH); count is allocated entries.
REQ-022 Sequential PC: on request handshake, fetch_pc advances by 4, wrapping modulo 2^WORD_BITWIDTH.
REQ-023 Response fill: each response accepted when drop == 0 fills the oldest unfilled entry.
REQ-024 Response drop: each response accepted when drop > 0 is discarded and drop decrements by 1.
REQ-025 Orphan response: a response with no unfilled entry and drop == 0 is ignored.
REQ-026 Output: inst_valid is high when the head entry is filled and redirect is low; inst and inst_pc come from the head entry.
REQ-027 Fill-to-output: a fill becomes visible the cycle after it; no response-to-output bypass.
REQ-028 Minimum latency: request at cycle t, response at t+1, inst_valid at t+2.
REQ-029 Redirect, PC: fetch_pc <= {redirect_pc[W-1:2], 2'b00}.
REQ-030 Redirect, queue: all entries are invalidated (count <= 0, pointers reset).
REQ-031 Redirect, drop counter: drop <= drop + unfilled − (imem_resp_valid ? 1 : 0); a response arriving in the redirect cycle is always discarded.
REQ-032 Redirect priority: redirect overrides request and dequeue in the same cycle; no dequeue occurs.
REQ-033 Full queue: a queue full of filled entries with inst_ready low holds all state; fetch_pc is stable and no requests issue.
REQ-034 Simultaneous dequeue, fill and request in one cycle are all applied; count changes by the net amount.

Reset
REQ-035 rst high at a rising edge sets fetch_pc = RESET_PC, count = drop = 0 and all pointers = 0.
REQ-036 Outputs in the cycle after reset: imem_req_valid high (unless redirect), inst_valid low.
REQ-037 rst has priority over redirect and all handshakes.
REQ-038 Reset mid-operation discards all queued and in-flight state; the memory model SHALL be reset at the same time.

Verification
REQ-039 Reset with RESET_PC=0x100 and 1-cycle memory -> requests 0x100, 0x104, 0x108; inst_pc 0x100 with inst_valid two cycles after the first request.
REQ-040 inst_ready held low, DEPTH=4 -> exactly 4 requests issue, then imem_req_valid stays low; fetch_pc = start+0x10; a single dequeue re-enables exactly one request.
REQ-041 Redirect to 0x2002 with 3 responses outstanding -> fetch_pc = 0x2000; the next 3 responses are discarded; first inst_pc = 0x2000.
REQ-042 Redirect in the same cycle as a response and inst_ready high -> response discarded, no dequeue, inst_valid low that cycle.
REQ-043 fetch_pc = 0xFFFFFFFC request accepted -> fetch_pc = 0x00000000.
REQ-044 Random memory latency 1–5 with random stalls and redirects, checked against a golden PC model -> every delivered inst_pc/inst pair matches and no stale instruction appears.
